// File: rtl/gate_deglitcher_mc.sv
// Multi-channel counter-based deglitcher: synchroniser + 4-state stability FSM per channel,
// separate rise/fall thresholds, 1-clock edge strobes. Optional glitch counters: GLITCH_CNT_EN.
module gate_deglitcher_mc #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int INIT_LEVEL  = 0,
    parameter int GCNT_W      = 16,
    localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic [N_CH-1:0]   degl_in,
    input  logic [CNT_W-1:0]  rise_len,
    input  logic [CNT_W-1:0]  fall_len,
    output logic [N_CH-1:0]   degl_out,
    output logic [N_CH-1:0]   rise_stb,
    output logic [N_CH-1:0]   fall_stb,
    input  logic [SEL_W-1:0]  glitch_sel,
    input  logic              glitch_clr,
    output logic [GCNT_W-1:0] glitch_cnt
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    localparam logic   INIT_BIT   = (INIT_LEVEL != 0);
    localparam state_t STATE_INIT = INIT_BIT ? STABLE_HI : STABLE_LO;

    logic [SYNC_STAGES-1:0] sync_q [N_CH];
    logic [N_CH-1:0]        s;

    state_t           state_q [N_CH];
    state_t           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [CNT_W-1:0] cnt_sat [N_CH];
    logic [CNT_W:0]   cnt_p1  [N_CH];

    logic [N_CH-1:0] out_q, out_d;
    logic [N_CH-1:0] rise_q, rise_d;
    logic [N_CH-1:0] fall_q, fall_d;
    logic [N_CH-1:0] glitch;

    logic [CNT_W-1:0] l_rise, l_fall;

    // A zero length would never be reached by a counter starting at 1, so treat it as 1.
    assign l_rise = (rise_len == '0) ? CNT_W'(1) : rise_len;
    assign l_fall = (fall_len == '0) ? CNT_W'(1) : fall_len;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            s[i]       = sync_q[i][SYNC_STAGES-1];
            cnt_p1[i]  = {1'b0, cnt_q[i]} + (CNT_W+1)'(1);
            cnt_sat[i] = (&cnt_q[i]) ? cnt_q[i] : cnt_p1[i][CNT_W-1:0];
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
        end
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        glitch = '0;

        for (int i = 0; i < N_CH; i++) begin
            case (state_q[i])
                STABLE_LO: begin
                    if (s[i]) begin
                        cnt_d[i] = CNT_W'(1);
                        if (l_rise == CNT_W'(1)) begin
                            state_d[i] = STABLE_HI;
                            out_d[i]   = 1'b1;
                            rise_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = PEND_HI;
                        end
                    end
                end
                PEND_HI: begin
                    if (!s[i]) begin
                        state_d[i] = STABLE_LO;
                        cnt_d[i]   = '0;
                        glitch[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_sat[i];
                        // >= so a threshold lowered mid-pend takes effect on the next clock.
                        if (cnt_p1[i] >= {1'b0, l_rise}) begin
                            state_d[i] = STABLE_HI;
                            out_d[i]   = 1'b1;
                            rise_d[i]  = 1'b1;
                        end
                    end
                end
                STABLE_HI: begin
                    if (!s[i]) begin
                        cnt_d[i] = CNT_W'(1);
                        if (l_fall == CNT_W'(1)) begin
                            state_d[i] = STABLE_LO;
                            out_d[i]   = 1'b0;
                            fall_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = PEND_LO;
                        end
                    end
                end
                PEND_LO: begin
                    if (s[i]) begin
                        state_d[i] = STABLE_HI;
                        cnt_d[i]   = '0;
                        glitch[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_sat[i];
                        if (cnt_p1[i] >= {1'b0, l_fall}) begin
                            state_d[i] = STABLE_LO;
                            out_d[i]   = 1'b0;
                            fall_d[i]  = 1'b1;
                        end
                    end
                end
                default: state_d[i] = STATE_INIT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < N_CH; i++) begin
                sync_q[i]  <= {SYNC_STAGES{INIT_BIT}};
                state_q[i] <= STATE_INIT;
                cnt_q[i]   <= '0;
            end
            out_q  <= {N_CH{INIT_BIT}};
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], degl_in[i]};
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign degl_out = out_q;
    assign rise_stb = rise_q;
    assign fall_stb = fall_q;

`ifdef GLITCH_CNT_EN
    logic [GCNT_W-1:0] gcnt_q [N_CH];
    logic [GCNT_W-1:0] gcnt_rd;
    logic [GCNT_W-1:0] glitch_cnt_q;

    // Selects that match no channel fall through to zero.
    always_comb begin
        gcnt_rd = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (glitch_sel == SEL_W'(i)) gcnt_rd = gcnt_q[i];
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < N_CH; i++) gcnt_q[i] <= '0;
            glitch_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (glitch_clr)
                    gcnt_q[i] <= '0;
                else if (glitch[i] && !(&gcnt_q[i]))
                    gcnt_q[i] <= gcnt_q[i] + GCNT_W'(1);
            end
            glitch_cnt_q <= gcnt_rd;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`else
    logic unused_glitch;
    assign unused_glitch = ^{glitch_sel, glitch_clr, glitch};
    assign glitch_cnt    = '0;
`endif

endmodule

// File: tb/tb_gate_deglitcher_mc.sv
// Directed bench for gate_deglitcher_mc: one INIT_LEVEL=0 instance and one INIT_LEVEL=1
// instance (narrow glitch counter) driven from the same stimulus.
module tb_gate_deglitcher_mc;

`ifdef GLITCH_CNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        nreset;
    logic [3:0]  degl_in;
    logic [9:0]  rise_len, fall_len;
    logic [1:0]  glitch_sel;
    logic        glitch_clr;

    logic [3:0]  degl_out, rise_stb, fall_stb;
    logic [15:0] glitch_cnt;
    logic [3:0]  degl_out_hi, rise_stb_hi, fall_stb_hi;
    logic [3:0]  glitch_cnt_hi;

    int checks   = 0;
    int failures = 0;

    gate_deglitcher_mc #(.N_CH(4), .CNT_W(10), .SYNC_STAGES(2), .INIT_LEVEL(0), .GCNT_W(16)) dut (
        .clock(clock), .nreset(nreset), .degl_in(degl_in),
        .rise_len(rise_len), .fall_len(fall_len),
        .degl_out(degl_out), .rise_stb(rise_stb), .fall_stb(fall_stb),
        .glitch_sel(glitch_sel), .glitch_clr(glitch_clr), .glitch_cnt(glitch_cnt)
    );

    gate_deglitcher_mc #(.N_CH(4), .CNT_W(10), .SYNC_STAGES(2), .INIT_LEVEL(1), .GCNT_W(4)) dut_hi (
        .clock(clock), .nreset(nreset), .degl_in(degl_in),
        .rise_len(rise_len), .fall_len(fall_len),
        .degl_out(degl_out_hi), .rise_stb(rise_stb_hi), .fall_stb(fall_stb_hi),
        .glitch_sel(glitch_sel), .glitch_clr(glitch_clr), .glitch_cnt(glitch_cnt_hi)
    );

    always #5 clock = ~clock;

    // Returns 1 time unit after a rising edge: outputs are settled, inputs may be driven.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0; degl_in = '0; rise_len = 10'd5; fall_len = 10'd3;
        glitch_sel = '0; glitch_clr = 1'b0;
        tick(3);
        checks++; if (degl_out !== 4'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", degl_out); end
        checks++; if (degl_out_hi !== 4'hF) begin failures++; $display("FAIL reset_out_hi got=%h exp=f", degl_out_hi); end
        checks++; if ({rise_stb, fall_stb, rise_stb_hi, fall_stb_hi} !== 16'h0) begin failures++; $display("FAIL reset_stb got=%h exp=0", {rise_stb, fall_stb, rise_stb_hi, fall_stb_hi}); end
        checks++; if ({glitch_cnt, glitch_cnt_hi} !== 20'h0) begin failures++; $display("FAIL reset_gcnt got=%h exp=0", {glitch_cnt, glitch_cnt_hi}); end
        nreset = 1'b1;
        tick(2);
        checks++; if (degl_out !== 4'h0 || rise_stb !== 4'h0) begin failures++; $display("FAIL post_reset got=%h/%h exp=0/0", degl_out, rise_stb); end
    endtask

    // ch0 held high with rise_len=5: output and strobe exactly at +7 clocks.
    task automatic test_rise_latency();
        rise_len = 10'd5;
        degl_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++; if (degl_out[0] !== (k >= 7)) begin failures++; $display("FAIL rise_lat_out k=%0d got=%b exp=%b", k, degl_out[0], (k >= 7)); end
            checks++; if (rise_stb[0] !== (k == 7)) begin failures++; $display("FAIL rise_lat_stb k=%0d got=%b exp=%b", k, rise_stb[0], (k == 7)); end
        end
    endtask

    // ch1 4-clock pulse with rise_len=5 never reaches the output; one glitch recorded.
    task automatic test_short_pulse();
        degl_in[1] = 1'b1;
        tick(4);
        degl_in[1] = 1'b0;
        for (int k = 5; k <= 12; k++) begin
            tick();
            checks++; if (degl_out[1] !== 1'b0 || rise_stb[1] !== 1'b0) begin failures++; $display("FAIL pulse_blocked k=%0d got=%b/%b exp=0/0", k, degl_out[1], rise_stb[1]); end
        end
        glitch_sel = 2'd1;
        tick(2);
        checks++; if (glitch_cnt !== (GC_EN ? 16'd1 : 16'd0)) begin failures++; $display("FAIL pulse_gcnt got=%0d exp=%0d", glitch_cnt, (GC_EN ? 1 : 0)); end
    endtask

    // rise_len 0 and 1 behave identically: output at +3 clocks on ch3.
    task automatic test_min_len();
        for (int r = 0; r < 2; r++) begin
            rise_len = 10'(r);
            degl_in[3] = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                tick();
                checks++; if (degl_out[3] !== (k >= 3)) begin failures++; $display("FAIL minlen_out len=%0d k=%0d got=%b exp=%b", r, k, degl_out[3], (k >= 3)); end
                checks++; if (rise_stb[3] !== (k == 3)) begin failures++; $display("FAIL minlen_stb len=%0d k=%0d got=%b exp=%b", r, k, rise_stb[3], (k == 3)); end
            end
            degl_in[3] = 1'b0;
            tick(8);
            checks++; if (degl_out[3] !== 1'b0) begin failures++; $display("FAIL minlen_fall len=%0d got=%b exp=0", r, degl_out[3]); end
        end
    endtask

    // ch0 high, fall_len=3: 2-clock low pulse is filtered, held low falls at +5.
    task automatic test_fall();
        fall_len = 10'd3;
        degl_in[0] = 1'b0;
        tick(2);
        degl_in[0] = 1'b1;
        for (int k = 3; k <= 10; k++) begin
            tick();
            checks++; if (degl_out[0] !== 1'b1 || fall_stb[0] !== 1'b0) begin failures++; $display("FAIL fall_glitch k=%0d got=%b/%b exp=1/0", k, degl_out[0], fall_stb[0]); end
        end
        degl_in[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++; if (degl_out[0] !== (k < 5)) begin failures++; $display("FAIL fall_out k=%0d got=%b exp=%b", k, degl_out[0], (k < 5)); end
            checks++; if (fall_stb[0] !== (k == 5) || rise_stb[0] !== 1'b0) begin failures++; $display("FAIL fall_stb k=%0d got=%b/%b exp=%b/0", k, fall_stb[0], rise_stb[0], (k == 5)); end
        end
    endtask

    // ch2 pending with cnt=3 under rise_len=8; lowering to 2 completes next clock.
    task automatic test_len_change();
        rise_len = 10'd8;
        degl_in[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++; if (degl_out[2] !== 1'b0) begin failures++; $display("FAIL lenchg_pend k=%0d got=%b exp=0", k, degl_out[2]); end
        end
        rise_len = 10'd2;
        tick();
        checks++; if (degl_out[2] !== 1'b1 || rise_stb[2] !== 1'b1) begin failures++; $display("FAIL lenchg_hi got=%b/%b exp=1/1", degl_out[2], rise_stb[2]); end
        tick();
        checks++; if (degl_out[2] !== 1'b1 || rise_stb[2] !== 1'b0) begin failures++; $display("FAIL lenchg_stb1 got=%b/%b exp=1/0", degl_out[2], rise_stb[2]); end
    endtask

    // Reset mid-pend: INIT_LEVEL=1 instance restarts HI with no strobes, then refilters.
    task automatic test_reset_midpend();
        rise_len = 10'd2; fall_len = 10'd3;
        degl_in = 4'hF;
        tick(10);
        checks++; if (degl_out !== 4'hF || degl_out_hi !== 4'hF) begin failures++; $display("FAIL midpend_setup got=%h/%h exp=f/f", degl_out, degl_out_hi); end
        degl_in = 4'h0;
        tick(3);
        nreset = 1'b0;
        #1;
        checks++; if (degl_out_hi !== 4'hF || degl_out !== 4'h0) begin failures++; $display("FAIL midpend_async got=%h/%h exp=f/0", degl_out_hi, degl_out); end
        checks++; if ({rise_stb, fall_stb, rise_stb_hi, fall_stb_hi} !== 16'h0) begin failures++; $display("FAIL midpend_stb got=%h exp=0", {rise_stb, fall_stb, rise_stb_hi, fall_stb_hi}); end
        checks++; if ({glitch_cnt, glitch_cnt_hi} !== 20'h0) begin failures++; $display("FAIL midpend_gcnt got=%h exp=0", {glitch_cnt, glitch_cnt_hi}); end
        tick(2);
        nreset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++; if (degl_out_hi !== ((k < 5) ? 4'hF : 4'h0)) begin failures++; $display("FAIL restart_out k=%0d got=%h exp=%h", k, degl_out_hi, ((k < 5) ? 4'hF : 4'h0)); end
            checks++; if (fall_stb_hi !== ((k == 5) ? 4'hF : 4'h0) || rise_stb_hi !== 4'h0) begin failures++; $display("FAIL restart_stb k=%0d got=%h/%h exp=%h/0", k, fall_stb_hi, rise_stb_hi, ((k == 5) ? 4'hF : 4'h0)); end
            checks++; if (degl_out !== 4'h0 || (rise_stb | fall_stb) !== 4'h0) begin failures++; $display("FAIL restart_lo k=%0d got=%h/%h exp=0/0", k, degl_out, rise_stb | fall_stb); end
        end
    endtask

    // 19 one-clock low glitches on HI ch0: 4-bit counter saturates, 16-bit counts 19; clear zeroes.
    task automatic test_glitch_sat();
        degl_in = 4'hF;
        tick(10);
        for (int g = 0; g < 19; g++) begin
            degl_in[0] = 1'b0;
            tick();
            degl_in[0] = 1'b1;
            tick(3);
        end
        glitch_sel = 2'd0;
        tick(2);
        checks++; if (degl_out_hi !== 4'hF || degl_out !== 4'hF) begin failures++; $display("FAIL gsat_out got=%h/%h exp=f/f", degl_out_hi, degl_out); end
        checks++; if (glitch_cnt_hi !== (GC_EN ? 4'hF : 4'h0)) begin failures++; $display("FAIL gsat_hi got=%0d exp=%0d", glitch_cnt_hi, (GC_EN ? 15 : 0)); end
        checks++; if (glitch_cnt !== (GC_EN ? 16'd19 : 16'd0)) begin failures++; $display("FAIL gsat_lo got=%0d exp=%0d", glitch_cnt, (GC_EN ? 19 : 0)); end
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        tick(2);
        checks++; if (glitch_cnt_hi !== 4'h0 || glitch_cnt !== 16'h0) begin failures++; $display("FAIL gclr got=%0d/%0d exp=0/0", glitch_cnt_hi, glitch_cnt); end
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_short_pulse();
        test_min_len();
        test_fall();
        test_len_change();
        test_reset_midpend();
        test_glitch_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
